// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver (and a future parity-capable transmitter).
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;
`endif

    localparam int PARITY_MAX_BITS = 32;

    function automatic int half_of(input int baud_divider);
        return baud_divider / 2;
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VALUE sets the value both flops take during reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: start/data/(parity)/stop framing, valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even parity bit between data and stop.
//
// state     | meaning
// IDLE      | line high, waiting for a falling edge on rx_sync
// START     | half-bit wait, then confirm start bit is still low
// DATA      | sample NUMBER_OF_BITS data bits, LSB first
// PARITY    | sample and check the even parity bit (parity builds only)
// STOP      | sample stop bit, deliver byte or flag framing error
// WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int NUMBER_OF_BITS = 8,
    parameter int BAUD_DIVIDER   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [NUMBER_OF_BITS-1:0] data_bits,
    output logic                      framing_error,
    output logic                      overrun,
    output logic                      parity_error
);

    localparam int HALF  = half_of(BAUD_DIVIDER);
    localparam int CNT_W = $clog2(BAUD_DIVIDER);
    localparam int IDX_W = $clog2(NUMBER_OF_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BAUD_DIVIDER - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUMBER_OF_BITS - 1);

    logic rx_sync;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_rx_sync (
        .clock_i (clock),
        .reset_ni(reset),
        .d_i     (rx),
        .q_o     (rx_sync)
    );

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUMBER_OF_BITS-1:0] shift_q, shift_d;
    logic [NUMBER_OF_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      fe_q, fe_d;
    logic                      ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
    logic                      perr_q, perr_d;
    logic                      pe_q, pe_d;
`endif

    logic                      sample;
    logic [NUMBER_OF_BITS:0]   shift_ext;

    assign sample    = (cnt_q == '0);
    assign shift_ext = {rx_sync, shift_q};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            pe_q    <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
        pe_d    = 1'b0;
`endif

        // A handshake clears the holding register; a delivery below may refill it.
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                    cnt_d   = HALF_RELOAD;
                end
            end

            START: begin
                cnt_d = sample ? BIT_RELOAD : cnt_q - 1'b1;
                if (sample) begin
                    if (rx_sync) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end
                end
            end

            DATA: begin
                cnt_d = sample ? BIT_RELOAD : cnt_q - 1'b1;
                if (sample) begin
                    shift_d = shift_ext[NUMBER_OF_BITS:1];
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_d = sample ? BIT_RELOAD : cnt_q - 1'b1;
                if (sample) begin
                    perr_d  = (rx_sync != even_parity(PARITY_MAX_BITS'(shift_q)));
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                cnt_d = sample ? BIT_RELOAD : cnt_q - 1'b1;
                if (sample) begin
`ifdef UART_RX_PARITY_EN
                    pe_d = perr_q;
`endif
                    if (rx_sync) begin
                        state_d = IDLE;
                        if (!valid_q || data_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                // A held break must not look like a new start bit.
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_valid    = valid_q;
    assign data_bits     = data_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = pe_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a monitor pops them on handshake.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

    localparam int N    = 8;
    localparam int BAUD = 4;
`ifdef UART_RX_PARITY_EN
    localparam int LATENCY = 45;
`else
    localparam int LATENCY = 41;
`endif

    logic         clock      = 1'b0;
    logic         reset      = 1'b0;
    logic         rx         = 1'b1;
    logic         data_ready = 1'b0;
    logic         data_valid;
    logic [N-1:0] data_bits;
    logic         framing_error;
    logic         overrun;
    logic         parity_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int last_start = 0;
    logic [N-1:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic flip_parity = 1'b0;
`endif

    uart_rx #(
        .NUMBER_OF_BITS(N),
        .BAUD_DIVIDER  (BAUD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_bits    (data_bits),
        .framing_error(framing_error),
        .overrun      (overrun),
        .parity_error (parity_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts error pulses and checks every accepted byte against the queue.
    always @(negedge clock) begin
        if (reset) begin
            if (framing_error) fe_cnt++;
            if (overrun)       ov_cnt++;
            if (parity_error)  pe_cnt++;
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none (cycle %0d)", data_bits, cyc);
                end else begin
                    chk("rx_byte", 32'(data_bits), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Behavioural transmitter; called on a falling clock edge, returns on one.
    task automatic send_frame(input logic [N-1:0] b, input logic stop_bit);
        rx = 1'b0;
        last_start = cyc;
        idle(BAUD);
        for (int i = 0; i < N; i++) begin
            rx = b[i];
            idle(BAUD);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ flip_parity;
        idle(BAUD);
`endif
        rx = stop_bit;
        idle(BAUD);
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (data_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        int fe0, ov0, pe0;
        logic [N-1:0] b;

        @(negedge clock);

        // Reset held with a toggling line: everything stays quiet.
        for (int i = 0; i < 20; i++) begin
            rx = i[0];
            @(negedge clock);
            chk("reset_outputs", 32'({data_valid, framing_error, overrun, parity_error, data_bits}), 32'd0);
        end
        rx = 1'b1;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (data_valid) seen = 1'b1;
        end
        chk("idle_no_valid", 32'(seen), 32'd0);

        // 0xA5: latency from start bit and one-cycle valid with ready high.
        data_ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_valid(10, ok);
        chk("a5_valid_seen", 32'(ok), 32'd1);
        chk("a5_latency", 32'(cyc - last_start), 32'(LATENCY));
        chk("a5_data", 32'(data_bits), 32'hA5);
        @(negedge clock);
        chk("a5_valid_clear", 32'(data_valid), 32'd0);
        idle(5);
        chk("a5_no_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)), 32'd0);

        // One-cycle glitch must be rejected, then 0x3C received.
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(10);
        chk("glitch_no_byte", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(10);
        chk("glitch_then_3c", 32'(exp_q.size()), 32'd0);
        chk("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);

        // 0x55 with a bad stop bit and a held break, then 0x0F.
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(10);
        chk("framing_pulse", 32'(fe_cnt - fe0), 32'd1);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        idle(10);
        chk("after_break_0f", 32'(exp_q.size()), 32'd0);
        chk("break_single_fe", 32'(fe_cnt - fe0), 32'd1);

        // Overrun: 0x11 held, 0x22 dropped.
        data_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(8);
        chk("overrun_pulse", 32'(ov_cnt - ov0), 32'd1);
        chk("overrun_valid_held", 32'(data_valid), 32'd1);
        chk("overrun_data_held", 32'(data_bits), 32'h11);
        @(posedge clock);
        #1 data_ready = 1'b1;
        @(negedge clock);
        idle(2);
        chk("overrun_valid_drop", 32'(data_valid), 32'd0);
        chk("overrun_drained", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Flipped parity bit: pulse reported, byte still delivered.
        pe0 = pe_cnt;
        exp_q.push_back(8'h96);
        flip_parity = 1'b1;
        send_frame(8'h96, 1'b1);
        flip_parity = 1'b0;
        idle(10);
        chk("parity_pulse", 32'(pe_cnt - pe0), 32'd1);
        chk("parity_byte_kept", 32'(exp_q.size()), 32'd0);
`endif

        // Back-to-back loopback with one reset mid-frame.
        ov0 = ov_cnt; fe0 = fe_cnt;
        for (int k = 0; k < 256; k++) begin
            b = N'($urandom_range(0, 255));
            if (k == 100) begin
                fork
                    send_frame(b, 1'b1);
                    begin
                        idle(15);
                        reset = 1'b0;
                    end
                join
                chk("reset_mid_valid", 32'(data_valid), 32'd0);
                idle(3);
                reset = 1'b1;
                idle(5);
            end else begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
            end
        end
        idle(10);
        chk("loopback_drain", 32'(exp_q.size()), 32'd0);
        chk("loopback_no_errors", 32'((ov_cnt - ov0) + (fe_cnt - fe0)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
